// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared constants and types for the single-cycle core's PC
//                sequencer: FSM state encoding, reset/exception vectors and
//                the sequential PC increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Sequencer FSM states. Encoding is visible on the board LEDs.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_HALT = 3'd3
    } state_t;

    localparam logic [7:0]  c_RESET_PC   = 8'h00;
    localparam logic [7:0]  c_EXC_VECTOR = 8'h80;
    localparam int unsigned c_PC_INC     = 4;

endpackage : core_pkg
`default_nettype wire

// File: rtl/pc_sequencer_step_sync.sv
`default_nettype none
// ============================================================================
//  Module      : step_sync
//  Description : Brings the raw single-step button into the clock domain with
//                a two-flop synchronizer and produces a one-cycle pulse on
//                each rising edge of the synchronized level.
//  Ports       : clk_i   - clock, rising edge
//                rst_i   - asynchronous active-high reset
//                btn_i   - raw asynchronous button level
//                rise_o  - single-cycle pulse per press
//  Revision    : 1.0 - initial release
// ============================================================================
module step_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            prev_q <= sync_q[1];
        end
    end

    // Holding the button keeps sync_q[1] high, so the pulse fires only once.
    assign rise_o = sync_q[1] & ~prev_q;

endmodule : step_sync
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program counter / exception PC owner for the single-cycle
//                core. Decides each cycle whether the instruction in flight
//                commits and computes the next PC. Adds run / single-step /
//                load / halt control for board-level operation.
//  Ports       : SYS_clk, SYS_reset (async, active-high)
//                SYS_load, SYS_pc_val   - forced PC load
//                run_en, step_btn       - free-run level / step button
//                branch_taken, branch_off, jump, jump_tgt - control flow
//                exception, halt_instr, exc_clr
//                pc, epc, commit_en, exc_pending, state, retired
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import core_pkg::*;
#(
    parameter int               PC_W       = 8,
    parameter logic [PC_W-1:0]  RESET_PC   = c_RESET_PC,
    parameter logic [PC_W-1:0]  EXC_VECTOR = c_EXC_VECTOR,
    parameter int               JT_W       = 6,
    parameter int               CNT_W      = 16
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              SYS_load,
    input  logic [PC_W-1:0]   SYS_pc_val,
    input  logic              run_en,
    input  logic              step_btn,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_off,
    input  logic              jump,
    input  logic [JT_W-1:0]   jump_tgt,
    input  logic              exception,
    input  logic              halt_instr,
    input  logic              exc_clr,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   epc,
    output logic              commit_en,
    output logic              exc_pending,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  retired
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             state_q,       state_d;
    logic [PC_W-1:0]    pc_q,          pc_d;
    logic [PC_W-1:0]    epc_q,         epc_d;
    logic               exc_pending_q, exc_pending_d;
    logic [CNT_W-1:0]   retired_q,     retired_d;

    // ------------------------------------------------------------------
    // Step button conditioning
    // ------------------------------------------------------------------
    logic w_step_rise;

    step_sync u_step_sync (
        .clk_i  (SYS_clk),
        .rst_i  (SYS_reset),
        .btn_i  (step_btn),
        .rise_o (w_step_rise)
    );

    // ------------------------------------------------------------------
    // Next-PC datapath
    // ------------------------------------------------------------------
    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_br_off;
    logic [PC_W-1:0] w_next_pc;

    assign w_pc_plus4 = pc_q + PC_W'(c_PC_INC);
    // Word offset to byte offset; bits shifted past PC_W are discarded.
    assign w_br_off   = branch_off << 2;

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump) begin
            // Jump keeps the region bits of pc+4 and replaces the low field.
            w_next_pc = {w_pc_plus4[PC_W-1:JT_W], jump_tgt};
        end else if (branch_taken) begin
            w_next_pc = w_pc_plus4 + w_br_off;
        end
    end

    // ------------------------------------------------------------------
    // Commit decision
    // ------------------------------------------------------------------
    logic w_act;

    assign w_act     = (state_q == ST_RUN) || (state_q == ST_STEP);
    // SYS_reset is included so commit drops the instant reset is applied,
    // independent of how fast the state flops clear.
    assign commit_en = w_act && !exception && !SYS_load && !halt_instr
                       && !SYS_reset;

    // ------------------------------------------------------------------
    // FSM next-state / register update
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        epc_d         = epc_q;
        retired_d     = retired_q;
        exc_pending_d = exc_clr ? 1'b0 : exc_pending_q;

        if (SYS_load) begin
            pc_d    = SYS_pc_val;
            state_d = ST_IDLE;
        end else if (w_act && exception) begin
            // Setting the flag overrides a simultaneous exc_clr.
            epc_d         = pc_q;
            pc_d          = EXC_VECTOR;
            exc_pending_d = 1'b1;
            state_d       = ((state_q == ST_RUN) && run_en) ? ST_RUN : ST_IDLE;
        end else if (w_act && halt_instr) begin
            state_d = ST_HALT;
        end else if (w_act) begin
            pc_d      = w_next_pc;
            retired_d = retired_q + CNT_W'(1);
            state_d   = ((state_q == ST_RUN) && run_en) ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run_en) begin
                        state_d = ST_RUN;
                    end else if (w_step_rise) begin
                        state_d = ST_STEP;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            epc_q         <= '0;
            exc_pending_q <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            exc_pending_q <= exc_pending_d;
            retired_q     <= retired_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc          = pc_q;
    assign epc         = epc_q;
    assign exc_pending = exc_pending_q;
    assign state       = state_q;
    assign retired     = retired_q;

endmodule : pc_sequencer
`default_nettype wire
